// File: rtl/mult16_seq.sv
// Sequential 16x16 shift-and-add multiplier (signed/unsigned) built around one FullAdder16.
// Latency 16 clocks from accept, or 18 when the result is negated.
// A start seen while busy is dropped; the caller must wait for busy=0 before issuing.

// 16-bit ripple-carry adder shared by every arithmetic step of the multiplier.
module FullAdder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[16];

endmodule

module mult16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        overflow
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    NEG_LO,
    NEG_HI,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] p;         // working register: accumulator high half, multiplier low half
  logic [15:0] mag_a;     // unsigned magnitude of the multiplicand
  logic        neg;       // result must be two's-complement negated at the end
  logic        sgn;       // mode latched at accept, used for the overflow rule
  logic [3:0]  cnt;       // CALC iteration index
  logic        carry;     // carry from NEG_LO into NEG_HI

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;
  logic [31:0] p_step;

  // Magnitude without an adder: -x flips every bit above the lowest set bit.
  // 0x8000 maps to itself, which is the wanted unsigned magnitude.
  function automatic logic [15:0] mag16(input logic [15:0] x, input logic en);
    logic [15:0] r;
    logic        seen;
    seen = 1'b0;
    r    = '0;
    for (int i = 0; i < 16; i++) begin
      r[i] = x[i] ^ seen;
      seen = seen | x[i];
    end
    return (en && x[15]) ? r : x;
  endfunction

  // Overflow: the 32-bit result is not representable in 16 bits of the chosen mode.
  function automatic logic ovf32(input logic [31:0] v, input logic s);
    return s ? (v[31:16] != {16{v[15]}}) : (v[31:16] != 16'h0000);
  endfunction

  FullAdder16 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // One shift-and-add iteration: add multiplicand when the multiplier LSB is set, then shift right.
  assign p_step = p[0] ? {add_cout, add_sum, p[15:1]} : {1'b0, p[31:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic, handshake outputs and adder operand steering.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        add_a = p[31:16];
        add_b = mag_a;
        if (cnt == 4'd15) state_next = neg ? NEG_LO : DONE;
      end
      NEG_LO: begin
        add_a      = ~p[15:0];
        add_cin    = 1'b1;
        state_next = NEG_HI;
      end
      NEG_HI: begin
        add_a      = ~p[31:16];
        add_cin    = carry;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration, negation and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p        <= '0;
      mag_a    <= '0;
      neg      <= 1'b0;
      sgn      <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mag_a <= mag16(a, signed_en);
            p     <= {16'h0000, mag16(b, signed_en)};
            neg   <= signed_en & (a[15] ^ b[15]);
            sgn   <= signed_en;
            cnt   <= '0;
            carry <= 1'b0;
          end
        end
        CALC: begin
          p   <= p_step;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15 && !neg) begin
            product  <= p_step;
            overflow <= ovf32(p_step, sgn);
          end
        end
        NEG_LO: begin
          p[15:0] <= add_sum;
          carry   <= add_cout;
        end
        NEG_HI: begin
          p[31:16] <= add_sum;
          product  <= {add_sum, p[15:0]};
          overflow <= ovf32({add_sum, p[15:0]}, sgn);
        end
        default: ;
      endcase
    end
  end

endmodule
